// File: rtl/at_pll_pkg.sv
// Shared types, default constants and phase-decode helper for the oversampled
// phase-shift clock generator.
package at_pll_pkg;

    typedef enum logic [1:0] {
        UNLOCKED,
        ACQUIRE,
        LOCKED
    } state_t;

    localparam int DIV      = 16;
    localparam int PH0      = 1;
    localparam int PH1      = 4;
    localparam int PH2      = 6;
    localparam int TOL      = 1;
    localparam int LOCK_CNT = 4;
    localparam int SYNC_LAT = 4;

    // True for the first half of the cycle that starts `offset` steps after phase 0.
    function automatic logic phaseHigh(input int phase, input int offset, input int div);
        int d;
        d = phase - offset;
        if (d < 0) begin
            d = d + div;
        end
        return (d < div / 2);
    endfunction

endpackage

// File: rtl/at_pll_sync_edge.sv
// Two-flop synchronizer for the reference clock followed by a rising-edge
// detector producing a single-cycle pulse in the BCLK domain.
module at_pll_sync_edge (
    input  logic BCLK,
    input  logic rst,
    input  logic i_async,
    output logic o_edge
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge BCLK or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_edge = r_sync & ~r_prev;

endmodule

// File: rtl/at_pll.sv
// Digitally oversampled phase-shift clock generator: measures the reference
// period, locks after a run of stable periods and regenerates shifted copies.
module at_pll #(
    parameter int DIV      = at_pll_pkg::DIV,
    parameter int PH0      = at_pll_pkg::PH0,
    parameter int PH1      = at_pll_pkg::PH1,
    parameter int PH2      = at_pll_pkg::PH2,
    parameter int TOL      = at_pll_pkg::TOL,
    parameter int LOCK_CNT = at_pll_pkg::LOCK_CNT,
    parameter int SYNC_LAT = at_pll_pkg::SYNC_LAT
) (
    input  logic BCLK,
    input  logic rst,
    input  logic inclk0,
    output logic c0,
    output logic c1,
    output logic c2,
    output logic locked
);

    import at_pll_pkg::state_t;
    import at_pll_pkg::UNLOCKED;
    import at_pll_pkg::ACQUIRE;
    import at_pll_pkg::LOCKED;
    import at_pll_pkg::phaseHigh;

    localparam int PW = $clog2(DIV);
    localparam int CW = $clog2(2 * DIV) + 1;
    localparam int GW = $clog2(LOCK_CNT + 1);

    localparam logic [CW-1:0] PER_MAX   = CW'(2 * DIV);
    localparam logic [CW-1:0] GOOD_MIN  = CW'(DIV - TOL);
    localparam logic [CW-1:0] GOOD_MAX  = CW'(DIV + TOL);
    localparam logic [PW-1:0] PH_LOAD   = PW'(SYNC_LAT % DIV);
    localparam logic [PW-1:0] PH_LAST   = PW'(DIV - 1);
    localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);

    logic          w_edge;
    logic          w_good;
    logic          w_timeout;
    logic          w_isLocked;
    logic          w_c0;
    logic          w_c1;
    logic          w_c2;
    logic [CW-1:0] r_period;
    logic [PW-1:0] r_phase;
    logic [GW-1:0] r_good;
    state_t        r_state;

    at_pll_sync_edge u_syncEdge (
        .BCLK    (BCLK),
        .rst     (rst),
        .i_async (inclk0),
        .o_edge  (w_edge)
    );

    // A simultaneous edge wins over timeout so that the saturated period is judged.
    always_comb begin
        w_good     = (r_period >= GOOD_MIN) && (r_period <= GOOD_MAX);
        w_timeout  = (r_period == PER_MAX) && !w_edge;
        w_isLocked = (r_state == LOCKED);
        w_c0       = w_isLocked && phaseHigh(int'(r_phase), PH0, DIV);
        w_c1       = w_isLocked && phaseHigh(int'(r_phase), PH1, DIV);
        w_c2       = w_isLocked && phaseHigh(int'(r_phase), PH2, DIV);
    end

    always_ff @(posedge BCLK or posedge rst) begin
        if (rst) begin
            r_period <= '0;
        end else if (w_edge) begin
            r_period <= CW'(1);
        end else if (r_period != PER_MAX) begin
            r_period <= r_period + 1'b1;
        end
    end

    always_ff @(posedge BCLK or posedge rst) begin
        if (rst) begin
            r_state <= UNLOCKED;
            r_good  <= '0;
        end else if (w_edge || w_timeout) begin
            case (r_state)
                UNLOCKED: begin
                    if (w_edge) begin
                        r_state <= ACQUIRE;
                        r_good  <= '0;
                    end
                end
                ACQUIRE: begin
                    if (!w_edge) begin
                        r_state <= UNLOCKED;
                        r_good  <= '0;
                    end else if (!w_good) begin
                        r_good <= '0;
                    end else if (r_good == GOOD_LAST) begin
                        r_state <= LOCKED;
                        r_good  <= '0;
                    end else begin
                        r_good <= r_good + 1'b1;
                    end
                end
                LOCKED: begin
                    if (!w_edge || !w_good) begin
                        r_state <= UNLOCKED;
                        r_good  <= '0;
                    end
                end
                default: begin
                    r_state <= UNLOCKED;
                    r_good  <= '0;
                end
            endcase
        end
    end

    // Reloading with the pipeline latency keeps phase 0 on the true reference edge.
    always_ff @(posedge BCLK or posedge rst) begin
        if (rst) begin
            r_phase <= '0;
        end else if (w_edge) begin
            r_phase <= PH_LOAD;
        end else if (r_phase == PH_LAST) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + 1'b1;
        end
    end

    always_ff @(posedge BCLK or posedge rst) begin
        if (rst) begin
            c0     <= 1'b0;
            c1     <= 1'b0;
            c2     <= 1'b0;
            locked <= 1'b0;
        end else begin
            c0     <= w_c0;
            c1     <= w_c1;
            c2     <= w_c2;
            locked <= w_isLocked;
        end
    end

endmodule

// File: tb/tb_at_pll.sv
// Table-driven bench for at_pll: each record is one reference period with the
// expected lock status after its rising edge, plus hand-written corner cases.
module tb_at_pll;

    typedef struct {
        int   period;
        logic expLocked;
        logic checkWave;
    } vec_t;

    logic BCLK = 1'b0;
    logic rst;
    logic inclk0;
    logic c0;
    logic c1;
    logic c2;
    logic locked;

    vec_t       vecs[$];
    int         testsRun    = 0;
    int         testsFailed = 0;
    logic       prevLocked;
    logic       sLocked[0:63];
    logic [2:0] sOut[0:63];

    always #5 BCLK = ~BCLK;

    at_pll dut (
        .BCLK   (BCLK),
        .rst    (rst),
        .inclk0 (inclk0),
        .c0     (c0),
        .c1     (c1),
        .c2     (c2),
        .locked (locked)
    );

    task automatic addVec(input int period, input logic expLocked, input logic checkWave);
        vec_t v;
        v.period    = period;
        v.expLocked = expLocked;
        v.checkWave = checkWave;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input int idx,
                               input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s (vec %0d): got %h, expected %h", name, idx, got, exp);
        end
    endtask

    // One reference period: rise just after a BCLK edge, fall after `hi` cycles.
    task automatic applyStimulus(input int per, input int hi);
        for (int k = 0; k < per; k++) begin
            @(posedge BCLK);
            #1;
            if (k == 0) begin
                inclk0 = 1'b1;
            end else if (k == hi) begin
                inclk0 = 1'b0;
            end
            @(negedge BCLK);
            sLocked[k] = locked;
            sOut[k]    = {c0, c1, c2};
        end
    endtask

    // Ideal shifted copy: high for half a period starting `ph` cycles after the reference edge.
    function automatic logic expHigh(input int k, input int ph);
        int d;
        d = (k - ph) % 16;
        if (d < 0) d = d + 16;
        return (d < 8);
    endfunction

    task automatic applyRange(input int first, input int last);
        vec_t        v;
        logic [63:0] g0, g1, g2, e0, e1, e2;
        logic [2:0]  anyOn;
        for (int i = first; i <= last; i++) begin
            v = vecs[i];
            applyStimulus(v.period, v.period / 2);
            checkOutput("lockedBeforeEdge", i, 64'(sLocked[3]), 64'(prevLocked));
            checkOutput("lockedAfterEdge", i, 64'(sLocked[4]), 64'(v.expLocked));
            checkOutput("lockedEndOfPeriod", i, 64'(sLocked[v.period-1]), 64'(v.expLocked));
            if (v.expLocked && v.checkWave) begin
                g0 = '0; g1 = '0; g2 = '0; e0 = '0; e1 = '0; e2 = '0;
                for (int k = 0; k < v.period; k++) begin
                    g0[k] = sOut[k][2];
                    g1[k] = sOut[k][1];
                    g2[k] = sOut[k][0];
                    e0[k] = expHigh(k, 1);
                    e1[k] = expHigh(k, 4);
                    e2[k] = expHigh(k, 6);
                end
                checkOutput("c0Wave", i, g0, e0);
                checkOutput("c1Wave", i, g1, e1);
                checkOutput("c2Wave", i, g2, e2);
            end else if (!v.expLocked) begin
                anyOn = '0;
                for (int k = 4; k < v.period; k++) anyOn |= sOut[k];
                checkOutput("outputsOff", i, 64'(anyOn), 64'(0));
            end
            prevLocked = v.expLocked;
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0] anyOn;

        rst    = 1'b1;
        inclk0 = 1'b0;
        repeat (4) @(posedge BCLK);
        @(negedge BCLK);
        checkOutput("resetState", 0, 64'({locked, c0, c1, c2}), 64'(0));
        @(posedge BCLK);
        #1 rst = 1'b0;

        // Acquire, steady lock, tolerated jitter, one bad period and relock.
        addVec(16, 1'b0, 1'b0); addVec(16, 1'b0, 1'b0); addVec(16, 1'b0, 1'b0);
        addVec(16, 1'b0, 1'b0); addVec(16, 1'b1, 1'b0); addVec(16, 1'b1, 1'b1);
        addVec(15, 1'b1, 1'b1); addVec(17, 1'b1, 1'b0); addVec(16, 1'b1, 1'b0);
        addVec(19, 1'b1, 1'b1); addVec(16, 1'b0, 1'b0); addVec(16, 1'b0, 1'b0);
        addVec(16, 1'b0, 1'b0); addVec(16, 1'b0, 1'b0); addVec(16, 1'b0, 1'b0);
        addVec(16, 1'b1, 1'b0); addVec(16, 1'b1, 1'b1);
        // Reacquire after timeout.
        addVec(16, 1'b0, 1'b0); addVec(16, 1'b0, 1'b0); addVec(16, 1'b0, 1'b0);
        addVec(16, 1'b0, 1'b0); addVec(16, 1'b1, 1'b0); addVec(16, 1'b1, 1'b1);
        // Reacquire after asynchronous reset.
        addVec(16, 1'b0, 1'b0); addVec(16, 1'b0, 1'b0); addVec(16, 1'b0, 1'b0);
        addVec(16, 1'b0, 1'b0); addVec(16, 1'b1, 1'b0);
        // Out-of-tolerance jitter, then a period ending exactly at timeout.
        addVec(14, 1'b0, 1'b0); addVec(18, 1'b0, 1'b0); addVec(14, 1'b0, 1'b0);
        addVec(18, 1'b0, 1'b0); addVec(14, 1'b0, 1'b0); addVec(32, 1'b0, 1'b0);
        addVec(16, 1'b0, 1'b0); addVec(16, 1'b0, 1'b0); addVec(16, 1'b0, 1'b0);
        addVec(16, 1'b0, 1'b0); addVec(16, 1'b1, 1'b0);

        prevLocked = 1'b0;
        applyRange(0, 16);

        // Reference stops: timeout 32 cycles after the detected edge at cycle 3.
        applyStimulus(40, 8);
        checkOutput("timeoutStillLocked", 0, 64'(sLocked[35]), 64'(1));
        checkOutput("timeoutUnlocked", 0, 64'(sLocked[36]), 64'(0));
        anyOn = '0;
        for (int k = 36; k < 40; k++) anyOn |= sOut[k];
        checkOutput("timeoutOutputsOff", 0, 64'(anyOn), 64'(0));

        prevLocked = 1'b0;
        applyRange(17, 22);

        // Reset while locked, with all three outputs high.
        @(posedge BCLK);
        #1 inclk0 = 1'b1;
        repeat (6) @(posedge BCLK);
        #1;
        checkOutput("preReset", 0, 64'({locked, c0, c1, c2}), 64'(4'b1111));
        #2 rst = 1'b1;
        #1;
        checkOutput("asyncReset", 0, 64'({locked, c0, c1, c2}), 64'(0));
        repeat (2) @(posedge BCLK);
        #1 inclk0 = 1'b0;
        repeat (8) @(posedge BCLK);
        @(negedge BCLK);
        checkOutput("resetHold", 0, 64'({locked, c0, c1, c2}), 64'(0));
        @(posedge BCLK);
        #1 rst = 1'b0;

        prevLocked = 1'b0;
        applyRange(23, 27);

        @(posedge BCLK);
        #1 rst = 1'b1;
        repeat (3) @(posedge BCLK);
        #1 rst = 1'b0;

        prevLocked = 1'b0;
        applyRange(28, 38);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/at_pll.md
# at_pll

Digitally oversampled phase-shift clock generator replacing the vendor PLL in the SCSI DMA clock tree. It samples the 25 MHz CPU clock input with a fast clock, measures its period, declares lock after a run of stable periods, then regenerates three 50 %-duty copies at 22.5°, 90° and 135°. The outputs feed the parent's nCLK (inverted c0), BCLK domain (c1) and BBCLK (c2).

## Interface
- DIV, 16: BCLK cycles per nominal inclk0 period. Even, ≥ 8.
- PH0, 1: c0 phase offset in BCLK cycles (22.5° at DIV=16).
- PH1, 4: c1 phase offset (90°).
- PH2, 6: c2 phase offset (135°).
- TOL, 1: allowed period deviation in BCLK cycles.
- LOCK_CNT, 4: consecutive good periods required for lock.
- SYNC_LAT, 4: phase-counter load value compensating input latency (2 synchronizer flops + edge register + output register).

Ports:
- BCLK  in  1  oversampling clock, DIV × inclk0 frequency (400 MHz nominal).
- rst  in  1  reset, asynchronous, active-high.
- inclk0  in  1  reference clock (25 MHz), asynchronous to BCLK.
- c0  out  1  phase-shifted copy, PH0 offset.
- c1  out  1  phase-shifted copy, PH1 offset.
- c2  out  1  phase-shifted copy, PH2 offset.
- locked  out  1  high while the generator is locked.

## Operation
- inclk0 passes a 2-flop synchronizer; a rising-edge detect produces a 1-cycle pulse `edge`.
- Period counter: counts BCLK cycles since the last `edge`, saturating at 2·DIV. On `edge`, the measured value is evaluated, then the counter restarts at 1.
- Good period: |period − DIV| ≤ TOL. Timeout: counter reaches 2·DIV with no edge.
- States:
  - UNLOCKED: entered on reset. The first `edge` moves to ACQUIRE with good-count 0; that edge's period is not evaluated.
  - ACQUIRE: each good period increments good-count. When it reaches LOCK_CNT, go to LOCKED. A bad period clears good-count and stays in ACQUIRE. Timeout goes to UNLOCKED.
  - LOCKED: a bad period or timeout goes to UNLOCKED and clears good-count.
- Phase counter (0..DIV−1, wraps mod DIV): loaded with SYNC_LAT mod DIV on every `edge`, otherwise increments. This keeps phase 0 aligned to the true inclk0 rising edge within ±1 BCLK cycle.
- Output decode, registered: cN is high when (phase − PHN) mod DIV < DIV/2, giving 50 % duty.
- c0, c1, c2 are forced 0 whenever state ≠ LOCKED.
- locked is registered: (state == LOCKED).
- Reset mid-operation: all outputs go to 0 immediately (asynchronous) and state goes to UNLOCKED; lock must be reacquired.

## Timing
- Reset values: c0 = c1 = c2 = 0, locked = 0, state UNLOCKED, all counters 0.
- Lock latency: the first edge enters ACQUIRE; locked rises 1 cycle after the (LOCK_CNT+1)-th detected edge.
- Unlock latency: locked falls 1 cycle after a bad edge is detected, or 1 cycle after timeout. Outputs go low on the same cycle.
- Input-to-edge latency: 3 BCLK cycles (2 sync + detect); compensated by SYNC_LAT.
- Simultaneous edge and timeout on the same cycle: the edge takes priority, and the period is evaluated (it is bad, since 2·DIV > DIV+TOL).
- Counter widths: $clog2(2·DIV)+1 bits. Phase counter: $clog2(DIV) bits.

## Structure
- Package at_pll_pkg holds:
  - the state enum {UNLOCKED, ACQUIRE, LOCKED};
  - default constants DIV, PH0..PH2, TOL, LOCK_CNT, SYNC_LAT.
- Sub-module at_pll_sync_edge: 2-flop synchronizer plus rising-edge pulse, reset by rst.
- The top level holds the period counter, FSM, phase counter and output decode.

## Test plan
- Reset then clean inclk0 (period 16 BCLK) → locked rises 1 cycle after the 5th detected edge; c0/c1/c2 are 0 before that.
- Locked and steady → c0/c1/c2 rise 1/4/6 BCLK after each inclk0 rising edge (±1), each high for 8 cycles.
- Period jitter of 15 and 17 cycles → stays locked. One period of 19 → locked and outputs drop 1 cycle after that edge, then relock after 4 further good periods.
- inclk0 held low → timeout at 32 cycles → locked = 0 and outputs 0.
- rst asserted mid-lock → outputs and locked go to 0 asynchronously; after release, lock takes LOCK_CNT+1 edges again.
- 5 alternating periods of 14 and 18 (bad with TOL=1) → never locks; outputs stay 0.
